// File: rtl/dma_seq_pkg.sv
// Shared types for the DMA tile sequencer: FSM states, error codes, descriptor layout.
// Optional watchdog in the sequencer is enabled with DMA_TILE_SEQ_TIMEOUT_EN.
package dma_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam logic [3:0] ERR_NONE    = 4'h0;
    localparam logic [3:0] ERR_TIMEOUT = 4'hF;

    localparam int DESC_ADDR_W = 32;
    localparam int DESC_LEN_W  = 32;

    // Datamover command word as presented on desc: length in the upper half.
    typedef struct packed {
        logic [DESC_LEN_W-1:0]  len;
        logic [DESC_ADDR_W-1:0] addr;
    } desc_t;

endpackage

// File: rtl/dma_seq_outstanding_ctr.sv
// Up/down counter of descriptors accepted but not yet completed, with full/empty flags.
// Simultaneous inc and dec leave the count unchanged; clr has priority.
module dma_seq_outstanding_ctr
    import dma_seq_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);
    localparam int W = $clog2(MAX_OUTSTANDING + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full  = (cnt_q == W'(MAX_OUTSTANDING));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/dma_tile_sequencer.sv
// Issues N equally strided DMA descriptors from one start pulse, bounding outstanding work.
// Define DMA_TILE_SEQ_TIMEOUT_EN to add a completion watchdog that aborts straight to DONE.
module dma_tile_sequencer
    import dma_seq_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_LEN_WIDTH   = 32,
    parameter int AXIS_USER_WIDTH = 65,
    parameter int CNT_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 65536
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    start,
    input  logic [AXI_ADDR_WIDTH-1:0]               cfg_base_addr,
    input  logic [AXI_LEN_WIDTH-1:0]                cfg_bytes,
    input  logic [AXI_ADDR_WIDTH-1:0]               cfg_stride,
    input  logic [CNT_WIDTH-1:0]                    cfg_count,
    input  logic [AXIS_USER_WIDTH-1:0]              cfg_user,
    output logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] desc,
    output logic [AXIS_USER_WIDTH-1:0]              desc_user,
    output logic                                    desc_valid,
    input  logic                                    desc_ready,
    input  logic                                    status_valid,
    input  logic [3:0]                              status_error,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    error,
    output logic [3:0]                              err_code,
    output logic [CNT_WIDTH-1:0]                    issued_cnt,
    output logic [CNT_WIDTH-1:0]                    completed_cnt
);
    // Handshake: a descriptor transfers on desc_valid && desc_ready; once raised,
    // desc_valid holds with desc/desc_user frozen until that handshake, except on abort.

    seq_state_e                 state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [AXI_ADDR_WIDTH-1:0]  stride_q, stride_d;
    logic [AXI_LEN_WIDTH-1:0]   bytes_q, bytes_d;
    logic [CNT_WIDTH-1:0]       count_q, count_d;
    logic [CNT_WIDTH-1:0]       issued_q, issued_d;
    logic [CNT_WIDTH-1:0]       completed_q, completed_d;
    logic [AXIS_USER_WIDTH-1:0] user_q, user_d;
    logic                       error_q, error_d;
    logic [3:0]                 err_code_q, err_code_d;

    logic out_full, out_empty, ctr_clr;
    logic desc_hs, status_ok, status_bad;

`ifdef DMA_TILE_SEQ_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wdog_fire;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    assign desc_valid = (state_q == RUN) && (issued_q < count_q) && !out_full;
    assign desc_hs    = desc_valid && desc_ready;
    // A status with nothing outstanding is stray and must not move any counter.
    assign status_ok  = status_valid && !out_empty;
    assign status_bad = status_ok && (status_error != ERR_NONE);

    dma_seq_outstanding_ctr #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_outstanding (
        .clk  (clk),
        .rstn (rstn),
        .clr  (ctr_clr),
        .inc  (desc_hs),
        .dec  (status_ok),
        .full (out_full),
        .empty(out_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        bytes_d     = bytes_q;
        count_d     = count_q;
        user_d      = user_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        ctr_clr     = 1'b0;

        if (status_ok) begin
            completed_d = completed_q + 1'b1;
        end
        if (status_bad && !error_q) begin
            error_d    = 1'b1;
            err_code_d = status_error;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = cfg_base_addr;
                    stride_d    = cfg_stride;
                    bytes_d     = cfg_bytes;
                    count_d     = cfg_count;
                    user_d      = cfg_user;
                    issued_d    = '0;
                    completed_d = '0;
                    error_d     = 1'b0;
                    err_code_d  = ERR_NONE;
                    ctr_clr     = 1'b1;
                    // A zero-tile run still passes through DRAIN, which finds nothing outstanding.
                    state_d     = (cfg_count == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (desc_hs) begin
                    issued_d = issued_q + 1'b1;
                    addr_d   = addr_q + stride_q;
                end
                if (status_bad || (issued_d == count_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DMA_TILE_SEQ_TIMEOUT_EN
        wdog_d    = '0;
        wdog_fire = 1'b0;
        if (((state_q == RUN) || (state_q == DRAIN)) && !out_empty && !status_valid) begin
            if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                wdog_fire = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
        if (wdog_fire) begin
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = DONE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            bytes_q     <= '0;
            count_q     <= '0;
            user_q      <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            bytes_q     <= bytes_d;
            count_q     <= count_d;
            user_q      <= user_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

`ifdef DMA_TILE_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign desc          = {bytes_q, addr_q};
    assign desc_user     = user_q;
    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign issued_cnt    = issued_q;
    assign completed_cnt = completed_q;

endmodule
